// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM state
// encoding, line-level bit constants, parity type codes and the byte width.
package uart_tx_pkg;

  localparam int UART_DATA_W = 8;

  // Parity type codes as seen on the PAR_TYP input.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Line levels for the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Frame sequencer states. STOP2 is only reachable when the second stop
  // bit option is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for one UART frame byte. Even parity makes the total
// count of ones (data plus parity bit) even; odd parity makes it odd.
module uart_parity_calc
  import uart_tx_pkg::*;
(
  input  logic [UART_DATA_W-1:0] data,
  input  logic                   par_typ,
  output logic                   parity
);

  // Reduction XOR gives the even-parity bit; odd parity is its inverse.
  always_comb begin
    parity = (par_typ == PAR_ODD) ? ~^data : ^data;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
//
// Buffers one byte from the source, then sequences an external 8-bit
// serializer to put start, data (LSB first), optional parity and stop bits
// onto TX_OUT, one bit per CLK cycle.
//
// Handshake: a byte moves from the source into the hold register on every
// rising CLK edge where Data_Valid && accept. accept is high exactly when the
// hold register is empty; while accept is low the source keeps P_DATA and
// Data_Valid stable.
//
// Optional build macro UART_TX_STOP2_EN: adds the STOP2 input (latched at
// frame start) that appends a second stop bit to the frame.
//
// Debug visibility: the FSM state lives in the `state` signal (type
// uart_tx_pkg::tx_state_t) for checkers bound to this module.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_GAP    = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [UART_DATA_W-1:0] P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
`ifdef UART_TX_STOP2_EN
  input  logic                   STOP2,
`endif
  input  logic                   ser_done,
  input  logic                   ser_data,
  output logic                   ser_en,
  output logic [UART_DATA_W-1:0] ser_pdata,
  output logic                   accept,
  output logic                   busy,
  output logic                   TX_OUT
);

  // The serializer's bit counter is hard-wired to eight bits.
  if (DATA_WIDTH != UART_DATA_W) begin : g_width_check
    $error("uart_tx_ctrl: DATA_WIDTH must be 8");
  end

  // Gap counter just wide enough to hold MIN_GAP.
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  tx_state_t              state;
  tx_state_t              state_next;

  logic [UART_DATA_W-1:0] hold_q;
  logic                   hold_full;
  logic [UART_DATA_W-1:0] frame_q;
  logic                   par_en_q;
  logic                   par_typ_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   xfer;
  logic                   pop;
  logic                   gap_load;
  logic                   par_bit;
`ifdef UART_TX_STOP2_EN
  logic                   stop2_q;
`endif

  assign accept    = !hold_full;
  assign xfer      = Data_Valid && accept;
  // A frame starts (and the hold register empties) on IDLE -> START.
  assign pop       = (state == IDLE) && (state_next == START);
  // Every return to IDLE from a frame arms the inter-frame gap.
  assign gap_load  = (state != IDLE) && (state_next == IDLE);
  assign ser_pdata = frame_q;

  uart_parity_calc u_parity (
    .data    (frame_q),
    .par_typ (par_typ_q),
    .parity  (par_bit)
  );

  // State register; reset forces the line idle in the cycle it is taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one cycle per framing bit, DATA lasts until ser_done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (hold_full && (gap_q == '0)) begin
          state_next = START;
        end
      end
      START: begin
        state_next = DATA;
      end
      DATA: begin
        if (ser_done) begin
          state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        state_next = STOP;
      end
      STOP: begin
`ifdef UART_TX_STOP2_EN
        state_next = stop2_q ? uart_tx_pkg::STOP2 : IDLE;
`else
        state_next = IDLE;
`endif
      end
`ifdef UART_TX_STOP2_EN
      uart_tx_pkg::STOP2: begin
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: line level, serializer enable and busy flag.
  always_comb begin
    TX_OUT = STOP_BIT;
    ser_en = 1'b0;
    busy   = (state != IDLE);
    case (state)
      START: begin
        TX_OUT = START_BIT;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        // Dropping enable with bit 7 lets the serializer clear and idle high.
        ser_en = !ser_done;
      end
      PARITY: begin
        TX_OUT = par_bit;
      end
      default: begin
        TX_OUT = STOP_BIT;
        ser_en = 1'b0;
      end
    endcase
  end

  // Hold register: filled by the handshake, emptied by a frame start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else begin
      if (xfer) begin
        hold_q    <= P_DATA;
        hold_full <= 1'b1;
      end else if (pop) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Frame register and per-frame options, captured only at frame start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= 1'b0;
`endif
    end else if (pop) begin
      frame_q   <= hold_q;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= STOP2;
`endif
    end
  end

  // Inter-frame gap: loaded when a frame ends, counts down while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gap_q <= '0;
    end else if (gap_load) begin
      gap_q <= GAP_LOAD;
    end else if ((state == IDLE) && (gap_q != '0)) begin
      gap_q <= gap_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Two instances share clock, reset, data
// and parity controls: dut0 with MIN_GAP=0 and dut1 with MIN_GAP=4. Each has
// its own behavioural model of the 8-bit serializer. Frames are captured as
// a bit vector where bit i is the line level in the i-th busy cycle, and are
// compared against hand-computed constants.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
`ifdef UART_TX_STOP2_EN
  logic       stop2;
`endif
  logic       dv        [2];
  logic       ser_done  [2];
  logic       ser_data  [2];
  logic       ser_en    [2];
  logic [7:0] ser_pdata [2];
  logic       accept    [2];
  logic       busy      [2];
  logic       tx_out    [2];

  // Serializer model state.
  logic       s_act [2];
  logic [2:0] s_cnt [2];

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  // Serializer model: bit0 appears the cycle after the first enabled edge,
  // done rides along with bit7, and a cycle without enable clears it.
  assign ser_data[0] = s_act[0] ? ser_pdata[0][s_cnt[0]] : 1'b1;
  assign ser_done[0] = s_act[0] && (s_cnt[0] == 3'd7);
  assign ser_data[1] = s_act[1] ? ser_pdata[1][s_cnt[1]] : 1'b1;
  assign ser_done[1] = s_act[1] && (s_cnt[1] == 3'd7);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ser_en[i]) begin
        if (!s_act[i]) begin
          s_act[i] <= 1'b1;
          s_cnt[i] <= 3'd0;
        end else begin
          s_cnt[i] <= s_cnt[i] + 3'd1;
        end
      end else begin
        s_act[i] <= 1'b0;
        s_cnt[i] <= 3'd0;
      end
    end
  end

  uart_tx_ctrl #(.DATA_WIDTH(8), .MIN_GAP(0)) dut0 (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (dv[0]),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
`ifdef UART_TX_STOP2_EN
    .STOP2      (stop2),
`endif
    .ser_done   (ser_done[0]),
    .ser_data   (ser_data[0]),
    .ser_en     (ser_en[0]),
    .ser_pdata  (ser_pdata[0]),
    .accept     (accept[0]),
    .busy       (busy[0]),
    .TX_OUT     (tx_out[0])
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .MIN_GAP(4)) dut1 (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (dv[1]),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
`ifdef UART_TX_STOP2_EN
    .STOP2      (stop2),
`endif
    .ser_done   (ser_done[1]),
    .ser_data   (ser_data[1]),
    .ser_en     (ser_en[1]),
    .ser_pdata  (ser_pdata[1]),
    .accept     (accept[1]),
    .busy       (busy[1]),
    .TX_OUT     (tx_out[1])
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the handshake completes.
  task automatic send_byte(input int sel, input logic [7:0] b);
    int guard;
    guard     = 0;
    p_data    = b;
    dv[sel]   = 1'b1;
    while (accept[sel] !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL send_accept_timeout: dut%0d accept=%b required 1", sel, accept[sel]);
    end
    tick();
    dv[sel] = 1'b0;
  endtask

  // Count idle cycles until busy, then record the line level for each busy cycle.
  task automatic collect_frame(input int sel, output logic [15:0] bits,
                               output int len, output int idle);
    bits = '0;
    len  = 0;
    idle = 0;
    while (busy[sel] !== 1'b1 && idle < 60) begin
      idle++;
      tick();
    end
    checks++;
    if (idle >= 60) begin
      errors++;
      $display("FAIL frame_start_timeout: dut%0d busy=%b required 1", sel, busy[sel]);
    end
    while (busy[sel] === 1'b1 && len < 16) begin
      bits[len] = tx_out[sel];
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({tx_out[i], ser_en[i], busy[i], accept[i]} !== 4'b1001 || ser_pdata[i] !== 8'h00) begin
          errors++;
          $display("FAIL reset_hold: dut%0d tx/en/busy/acc=%b%b%b%b pdata=%h required 1001 00",
                   i, tx_out[i], ser_en[i], busy[i], accept[i], ser_pdata[i]);
        end
      end
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({tx_out[i], ser_en[i], busy[i], accept[i]} !== 4'b1001) begin
          errors++;
          $display("FAIL idle_after_reset: dut%0d tx/en/busy/acc=%b%b%b%b required 1001",
                   i, tx_out[i], ser_en[i], busy[i], accept[i]);
        end
      end
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] bits;
    int          len;
    int          idle;
    par_en  = 1'b0;
    par_typ = 1'b0;
    send_byte(0, 8'hA5);
    // Byte sits in the hold register for one idle cycle.
    checks++;
    if (accept[0] !== 1'b0 || busy[0] !== 1'b0 || tx_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_accept: acc=%b busy=%b tx=%b required 0 0 1",
               accept[0], busy[0], tx_out[0]);
    end
    collect_frame(0, bits, len, idle);
    checks++;
    if (idle != 1) begin
      errors++;
      $display("FAIL single_start_latency: idle=%0d required 1", idle);
    end
    // start 0, A5 LSB first 1,0,1,0,0,1,0,1, stop 1
    checks++;
    if (bits !== 16'h034A) begin
      errors++;
      $display("FAIL single_bits: got %h required 034a", bits);
    end
    checks++;
    if (len != 10) begin
      errors++;
      $display("FAIL single_len: got %0d required 10", len);
    end
    checks++;
    if (ser_pdata[0] !== 8'hA5 || tx_out[0] !== 1'b1 || accept[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_after: pdata=%h tx=%b acc=%b required a5 1 1",
               ser_pdata[0], tx_out[0], accept[0]);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  tbytes [3] = '{8'h07, 8'h07, 8'h00};
    logic        ttyp   [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] texp   [3] = '{16'h060E, 16'h040E, 16'h0600};
    logic [15:0] bits;
    int          len;
    int          idle;
    for (int k = 0; k < 3; k++) begin
      par_en  = 1'b1;
      par_typ = ttyp[k];
      send_byte(0, tbytes[k]);
      collect_frame(0, bits, len, idle);
      checks++;
      if (bits !== texp[k] || len != 11) begin
        errors++;
        $display("FAIL parity_frame%0d: got %h len %0d required %h len 11", k, bits, len, texp[k]);
      end
    end
    // Parity controls changed after the frame starts must not matter.
    par_en  = 1'b1;
    par_typ = 1'b0;
    send_byte(0, 8'h07);
    fork
      collect_frame(0, bits, len, idle);
      begin
        repeat (4) tick();
        par_en  = 1'b0;
        par_typ = 1'b1;
      end
    join
    checks++;
    if (bits !== 16'h060E || len != 11) begin
      errors++;
      $display("FAIL parity_midframe: got %h len %0d required 060e len 11", bits, len);
    end
    par_en  = 1'b0;
    par_typ = 1'b0;
  endtask

  task automatic test_back_to_back(input int sel, input int exp_idle);
    logic [7:0]  tbytes [3] = '{8'h11, 8'h22, 8'h33};
    logic [15:0] texp   [3] = '{16'h0222, 16'h0244, 16'h0266};
    int          saw_low;
    int          late;
    saw_low = 0;
    par_en  = 1'b0;
    fork
      begin : drv
        int guard;
        for (int i = 0; i < 3; i++) begin
          p_data  = tbytes[i];
          dv[sel] = 1'b1;
          guard   = 0;
          while (accept[sel] !== 1'b1 && guard < 60) begin
            saw_low = 1;
            tick();
            guard++;
          end
          checks++;
          if (guard >= 60) begin
            errors++;
            $display("FAIL b2b_accept_timeout: dut%0d byte%0d", sel, i);
          end
          tick();
        end
        dv[sel] = 1'b0;
      end
      begin : mon
        logic [15:0] bits;
        int          len;
        int          idle;
        for (int f = 0; f < 3; f++) begin
          collect_frame(sel, bits, len, idle);
          checks++;
          if (bits !== texp[f] || len != 10) begin
            errors++;
            $display("FAIL b2b_frame: dut%0d frame%0d got %h len %0d required %h len 10",
                     sel, f, bits, len, texp[f]);
          end
          if (f > 0) begin
            checks++;
            if (idle != exp_idle) begin
              errors++;
              $display("FAIL b2b_gap: dut%0d frame%0d idle %0d required %0d", sel, f, idle, exp_idle);
            end
          end
        end
      end
    join
    checks++;
    if (saw_low != 1) begin
      errors++;
      $display("FAIL b2b_accept_drop: dut%0d accept never low, required low while hold full", sel);
    end
    // Exactly three frames: the line stays idle afterwards.
    late = 0;
    repeat (12) begin
      tick();
      if (busy[sel] !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL b2b_extra_frame: dut%0d busy cycles %0d required 0", sel, late);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    int          len;
    int          idle;
    int          busy_seen;
    par_en    = 1'b0;
    p_data    = 8'hFF;
    dv[0]     = 1'b1;
    tick();                   // FF transferred
    p_data    = 8'hAA;
    tick();                   // START, hold emptied
    checks++;
    if (tx_out[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_start: tx=%b busy=%b required 0 1", tx_out[0], busy[0]);
    end
    tick();                   // data bit 0, AA transferred
    dv[0] = 1'b0;
    repeat (3) tick();        // data bit 3
    checks++;
    if (accept[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bit3: acc=%b busy=%b required 0 1", accept[0], busy[0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({tx_out[0], ser_en[0], busy[0], accept[0]} !== 4'b1001 || ser_pdata[0] !== 8'h00) begin
      errors++;
      $display("FAIL midrst_line: tx/en/busy/acc=%b%b%b%b pdata=%h required 1001 00",
               tx_out[0], ser_en[0], busy[0], accept[0], ser_pdata[0]);
    end
    tick();
    checks++;
    if (ser_data[0] !== 1'b1 || tx_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ser_idle: ser_data=%b tx=%b required 1 1", ser_data[0], tx_out[0]);
    end
    rst = 1'b0;
    // The discarded hold byte must not start a frame.
    busy_seen = 0;
    repeat (6) begin
      tick();
      if (busy[0] !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL midrst_hold_discard: busy cycles %0d required 0", busy_seen);
    end
    send_byte(0, 8'h3C);
    collect_frame(0, bits, len, idle);
    checks++;
    if (bits !== 16'h0278 || len != 10) begin
      errors++;
      $display("FAIL midrst_next_frame: got %h len %0d required 0278 len 10", bits, len);
    end
  endtask

`ifdef UART_TX_STOP2_EN
  task automatic test_stop2();
    logic [15:0] bits;
    int          len;
    int          idle;
    par_en  = 1'b1;
    par_typ = 1'b0;
    stop2   = 1'b1;
    send_byte(0, 8'h07);
    collect_frame(0, bits, len, idle);
    checks++;
    if (bits !== 16'h0E0E || len != 12) begin
      errors++;
      $display("FAIL stop2_on: got %h len %0d required 0e0e len 12", bits, len);
    end
    stop2 = 1'b0;
    send_byte(0, 8'h07);
    collect_frame(0, bits, len, idle);
    checks++;
    if (bits !== 16'h060E || len != 11) begin
      errors++;
      $display("FAIL stop2_off: got %h len %0d required 060e len 11", bits, len);
    end
    par_en = 1'b0;
  endtask
`endif

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    p_data  = 8'h00;
    par_en  = 1'b0;
    par_typ = 1'b0;
    dv[0]   = 1'b0;
    dv[1]   = 1'b0;
`ifdef UART_TX_STOP2_EN
    stop2   = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back(0, 1);
    test_back_to_back(1, 5);
    test_reset_mid_frame();
`ifdef UART_TX_STOP2_EN
    test_stop2();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
